// File: rtl/char_inject_arbiter_if.sv
// Bundle of host-character, processor-dmem and RAM-side signals for char_inject_arbiter.
// CHAR_INJECT_SHIFT_EN adds the shift-amount register-write sideband.
interface char_inject_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CHAR_W = 8
);
  logic              in_valid;
  logic [CHAR_W-1:0] in_data;
  logic              in_ready;
  logic              clear;

  logic              cpu_mem_active;
  logic              cpu_wEn;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dataIn;
  logic              cpu_stall;

  logic              mem_wEn;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dataIn;

  logic [7:0]        count;
  logic              done;

`ifdef CHAR_INJECT_SHIFT_EN
  logic [4:0]        shift_amt;
  logic              cpu_rwe;
  logic [4:0]        cpu_rd;
  logic [31:0]       cpu_rData;
  logic              reg_we;
  logic [4:0]        reg_rd;
  logic [31:0]       reg_data;
`endif

  // Injector side.
  modport slave (
    input  in_valid, in_data, clear,
    input  cpu_mem_active, cpu_wEn, cpu_addr, cpu_dataIn,
    output in_ready, cpu_stall, mem_wEn, mem_addr, mem_dataIn, count, done
`ifdef CHAR_INJECT_SHIFT_EN
    ,
    input  shift_amt, cpu_rwe, cpu_rd, cpu_rData,
    output reg_we, reg_rd, reg_data
`endif
  );

  // Host / processor / RAM side.
  modport master (
    output in_valid, in_data, clear,
    output cpu_mem_active, cpu_wEn, cpu_addr, cpu_dataIn,
    input  in_ready, cpu_stall, mem_wEn, mem_addr, mem_dataIn, count, done
`ifdef CHAR_INJECT_SHIFT_EN
    ,
    output shift_amt, cpu_rwe, cpu_rd, cpu_rData,
    input  reg_we, reg_rd, reg_data
`endif
  );
endinterface

// File: rtl/char_inject_arbiter.sv
// Buffers host characters in a small FIFO and writes them into a RAM window, stealing idle
// dmem cycles and stalling the processor only when the FIFO is full. Option: CHAR_INJECT_SHIFT_EN.
module char_inject_arbiter #(
  parameter int unsigned BASE_ADDR  = 1500,
  parameter int unsigned DEPTH      = 108,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CHAR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clock,
  input logic                  reset,
  char_inject_arbiter_if.slave bus_io
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  logic [CHAR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]   occ_q, occ_d;
  logic [7:0]        count_q, count_d;
  state_e            state_q;
  logic              done_q;

  logic              fifo_full, fifo_empty;
  logic              in_ready, push, pop;
  logic [8:0]        fill_sum;

  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  assign fifo_full  = (occ_q == OccW'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);
  // Buffered plus committed characters must stay below the window size.
  assign fill_sum   = {1'b0, count_q} + 9'(occ_q);
  assign in_ready   = reset && !fifo_full && (state_q != StDone) && (fill_sum < 9'(DEPTH));

  // clear wins over both the commit and the push of the same cycle.
  assign push = bus_io.in_valid && in_ready && !bus_io.clear;
  assign pop  = reset && !bus_io.clear && !fifo_empty && (!bus_io.cpu_mem_active || fifo_full);

  always_comb begin
    mem_wen  = bus_io.cpu_wEn;
    mem_addr = bus_io.cpu_addr;
    mem_data = bus_io.cpu_dataIn;
    if (pop) begin
      mem_wen  = 1'b1;
      mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(count_q);
      mem_data = DATA_W'(fifo_mem[rd_ptr_q]);
    end
  end

  assign bus_io.in_ready   = in_ready;
  assign bus_io.cpu_stall  = pop && bus_io.cpu_mem_active;
  assign bus_io.mem_wEn    = mem_wen;
  assign bus_io.mem_addr   = mem_addr;
  assign bus_io.mem_dataIn = mem_data;
  assign bus_io.count      = count_q;
  assign bus_io.done       = done_q && reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    if (bus_io.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        count_d  = count_q + 8'd1;
      end
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: ;
      endcase
    end
  end

  // Storage is intentionally not reset; only the pointers give it meaning.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus_io.in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else if (bus_io.clear) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else if (pop) begin
      unique case (state_q)
        StIdle, StLoad: begin
          if (count_d == 8'(DEPTH)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StLoad;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHAR_INJECT_SHIFT_EN
  logic [4:0] shift_q;
  logic [4:0] pend_val_q, pend_val_d;
  logic       pend_q, pend_d;
  logic       issue;

  // The pending write waits for a cycle where the processor is not writing back.
  assign issue = reset && pend_q && !bus_io.cpu_rwe;

  always_comb begin
    pend_d     = pend_q && !issue;
    pend_val_d = pend_val_q;
    if (bus_io.shift_amt != shift_q) begin
      pend_d     = 1'b1;
      pend_val_d = bus_io.shift_amt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      shift_q    <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      shift_q    <= bus_io.shift_amt;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign bus_io.reg_we   = issue ? 1'b1 : bus_io.cpu_rwe;
  assign bus_io.reg_rd   = issue ? 5'd6 : bus_io.cpu_rd;
  assign bus_io.reg_data = issue ? {27'b0, pend_val_q} : bus_io.cpu_rData;
`endif

  a_count_bounded : assert property (@(posedge clock) disable iff (!reset)
    count_q <= 8'(DEPTH));
  a_no_push_full : assert property (@(posedge clock) disable iff (!reset)
    !(push && fifo_full));

endmodule

// File: tb/tb_char_inject_arbiter.sv
// Self-checking bench for char_inject_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_char_inject_arbiter;
  localparam int BASE = 1500;
  localparam int DEPTH = 108;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  char_inject_arbiter_if bus ();

  char_inject_arbiter dut (
    .clock (clk),
    .reset (rst_n),
    .bus_io(bus)
  );

  int n_checks = 0;
  int n_err = 0;

  // Reference model: buffered characters and committed count.
  byte unsigned q[$];
  int cnt_m = 0;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [7:0]  d;
    logic        act;
    logic        cwe;
    logic        rdy;
    logic        stall;
    logic        wen;
    logic [11:0] addr;
    logic [31:0] data;
    logic [7:0]  cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every output with the model, advance the model, then clock once.
  task automatic tick();
    bit ready, grant;
    int head;
    #1;
    ready = rst_n && (q.size() < FD) && ((cnt_m + q.size()) < DEPTH);
    grant = rst_n && !bus.clear && (q.size() > 0) && (!bus.cpu_mem_active || q.size() == FD);
    head = (q.size() > 0) ? int'(q[0]) : 0;
    chk("in_ready", bus.in_ready, ready);
    chk("cpu_stall", bus.cpu_stall, grant && bus.cpu_mem_active);
    chk("mem_wEn", bus.mem_wEn, grant ? 1'b1 : bus.cpu_wEn);
    chk("mem_addr", bus.mem_addr, grant ? BASE + cnt_m : bus.cpu_addr);
    chk("mem_dataIn", bus.mem_dataIn, grant ? head : bus.cpu_dataIn);
    chk("count", bus.count, cnt_m);
    chk("done", bus.done, rst_n && cnt_m == DEPTH);
    if (!rst_n || bus.clear) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (grant) begin
        void'(q.pop_front());
        cnt_m++;
      end
      if (bus.in_valid && ready) q.push_back(bus.in_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[14];
    bit seen_last;

    vec[0]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h123, 32'hDEADBEEF, 8'd0};
    vec[1]  = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 32'hDEADBEEF, 8'd0};
    vec[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd1500, 32'h41, 8'd0};
    vec[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h123, 32'hDEADBEEF, 8'd1};
    vec[4]  = '{1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 32'hDEADBEEF, 8'd1};
    vec[5]  = '{1'b1, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 32'hDEADBEEF, 8'd1};
    vec[6]  = '{1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 32'hDEADBEEF, 8'd1};
    vec[7]  = '{1'b1, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 32'hDEADBEEF, 8'd1};
    vec[8]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd1501, 32'hA1, 8'd1};
    vec[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 32'hDEADBEEF, 8'd2};
    vec[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd1502, 32'hA2, 8'd2};
    vec[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd1503, 32'hA3, 8'd3};
    vec[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd1504, 32'hA4, 8'd4};
    vec[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 32'hDEADBEEF, 8'd5};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.clear = 1'b0;
    bus.cpu_mem_active = 1'b0;
    bus.cpu_wEn = 1'b0;
    bus.cpu_addr = 12'h123;
    bus.cpu_dataIn = 32'hDEADBEEF;
`ifdef CHAR_INJECT_SHIFT_EN
    bus.shift_amt = 5'd0;
    bus.cpu_rwe = 1'b0;
    bus.cpu_rd = 5'd9;
    bus.cpu_rData = 32'h1234;
`endif
    @(posedge clk);
    @(negedge clk);

`ifdef CHAR_INJECT_SHIFT_EN
    rst_n = 1'b1;
    bus.shift_amt = 5'd3;
    bus.cpu_rwe = 1'b1;
    #1;
    chk("shift_hold_we", bus.reg_we, 1'b1);
    chk("shift_hold_rd", bus.reg_rd, 5'd9);
    tick();
    #1;
    chk("shift_hold2_rd", bus.reg_rd, 5'd9);
    chk("shift_hold2_data", bus.reg_data, 32'h1234);
    tick();
    bus.cpu_rwe = 1'b0;
    #1;
    chk("shift_issue_we", bus.reg_we, 1'b1);
    chk("shift_issue_rd", bus.reg_rd, 5'd6);
    chk("shift_issue_data", bus.reg_data, 32'd3);
    tick();
    #1;
    chk("shift_once_we", bus.reg_we, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
`endif

    // Vector table: reset, first commit, forced commits with the FIFO full.
    for (int i = 0; i < 14; i++) begin
      rst_n = vec[i].rst;
      bus.in_valid = vec[i].iv;
      bus.in_data = vec[i].d;
      bus.cpu_mem_active = vec[i].act;
      bus.cpu_wEn = vec[i].cwe;
      #1;
      chk($sformatf("vec%0d_ready", i), bus.in_ready, vec[i].rdy);
      chk($sformatf("vec%0d_stall", i), bus.cpu_stall, vec[i].stall);
      chk($sformatf("vec%0d_wen", i), bus.mem_wEn, vec[i].wen);
      chk($sformatf("vec%0d_addr", i), bus.mem_addr, vec[i].addr);
      chk($sformatf("vec%0d_data", i), bus.mem_dataIn, vec[i].data);
      chk($sformatf("vec%0d_count", i), bus.count, vec[i].cnt);
      tick();
    end

    // Fill the whole window with the CPU idle.
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.cpu_mem_active = 1'b0;
    bus.cpu_wEn = 1'b0;
    seen_last = 1'b0;
    for (int i = 0; i < 400 && bus.count != 8'd108; i++) begin
      bus.in_data = 8'($urandom_range(0, 255));
      #1;
      if (bus.mem_wEn && bus.count == 8'd107) begin
        seen_last = 1'b1;
        chk("last_addr", bus.mem_addr, 12'd1607);
      end
      tick();
    end
    chk("last_write_seen", seen_last, 1'b1);
    chk("fill_done", bus.done, 1'b1);
    chk("fill_count", bus.count, 8'd108);
    chk("fill_ready", bus.in_ready, 1'b0);
    bus.cpu_wEn = 1'b1;
    #1;
    chk("over_wen_tied1", bus.mem_wEn, 1'b1);
    tick();
    bus.cpu_wEn = 1'b0;
    #1;
    chk("over_wen_tied0", bus.mem_wEn, 1'b0);
    tick();
    chk("over_count", bus.count, 8'd108);

    // Restart, load 50, then clear together with a push.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int i = 0; i < 200 && bus.count != 8'd50; i++) begin
      bus.in_data = 8'($urandom_range(0, 255));
      tick();
    end
    chk("load50_count", bus.count, 8'd50);
    bus.clear = 1'b1;
    bus.in_data = 8'h99;
    #1;
    chk("clear_no_commit", bus.mem_wEn, 1'b0);
    tick();
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("clear_count", bus.count, 8'd0);
    chk("clear_fifo_empty", bus.mem_wEn, 1'b0);
    tick();
    bus.in_valid = 1'b1;
    bus.in_data = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("after_clear_wen", bus.mem_wEn, 1'b1);
    chk("after_clear_addr", bus.mem_addr, 12'd1500);
    chk("after_clear_data", bus.mem_dataIn, 32'h77);
    tick();

    // Reset with count=20 and three characters buffered.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && bus.count != 8'd20; i++) begin
      bus.in_data = 8'($urandom_range(0, 255));
      tick();
    end
    bus.cpu_mem_active = 1'b1;
    for (int i = 0; i < 10 && q.size() < 3; i++) begin
      bus.in_data = 8'($urandom_range(0, 255));
      tick();
    end
    chk("pre_reset_count", bus.count, 8'd20);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.in_ready, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_stall", bus.cpu_stall, 1'b0);
    chk("rst_wen", bus.mem_wEn, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.cpu_mem_active = 1'b0;
    #1;
    chk("post_rst_count", bus.count, 8'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("no_stale_write", bus.mem_wEn, 1'b0);
      tick();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 250) % 3;
      rst_n = ($urandom_range(0, 699) != 0);
      bus.clear = ($urandom_range(0, 79) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data = 8'($urandom_range(0, 255));
      bus.cpu_mem_active = (bias == 0) ? ($urandom_range(0, 3) == 0) :
                           (bias == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      bus.cpu_wEn = 1'($urandom_range(0, 1));
      bus.cpu_addr = 12'($urandom);
      bus.cpu_dataIn = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
